// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces one quotient bit per cycle. The unit is occupied for 34 cycles:
// accept, DATA_WIDTH iterations, then a single DONE cycle.
module ex_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem;        // partial remainder
  logic [W-1:0]  qd;         // dividend shifts out of the top, quotient shifts in at the bottom
  logic [W-1:0]  dsr;        // divisor magnitude
  logic [W-1:0]  raw1;       // unmodified dividend, returned as HI on divide-by-zero
  logic          sign_q, sign_r, div0;

  logic          accept, last;
  logic          neg1, neg2;
  logic [W-1:0]  mag1, mag2;
  logic [W+1:0]  trial;
  logic [W-1:0]  rem_nxt, qd_nxt, q_fin, r_fin;

  assign accept = (state == IDLE) && start && !flush;
  assign last   = (state == BUSY) && (cnt == CW'(DATA_WIDTH - 1));

  assign neg1 = is_signed & operand_1[W-1];
  assign neg2 = is_signed & operand_2[W-1];
  assign mag1 = neg1 ? -operand_1 : operand_1;
  assign mag2 = neg2 ? -operand_2 : operand_2;

  // Trial subtract with two extra bits so the sign is unambiguous even when
  // {rem, next bit} exceeds W bits.
  always_comb begin
    trial   = {1'b0, rem, qd[W-1]} - {2'b00, dsr};
    rem_nxt = trial[W+1] ? {rem[W-2:0], qd[W-1]} : trial[W-1:0];
    qd_nxt  = {qd[W-2:0], ~trial[W+1]};
    q_fin   = sign_q ? -qd_nxt  : qd_nxt;
    r_fin   = sign_r ? -rem_nxt : rem_nxt;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs; flush overrides everything
  always_comb begin
    state_nxt = state;
    busy      = accept || (state == BUSY);
    done      = (state == DONE) && !flush;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Operand capture, iteration, and result write on the final iteration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      rem    <= '0;
      qd     <= '0;
      dsr    <= '0;
      raw1   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      cnt    <= '0;
      rem    <= '0;
      qd     <= mag1;
      dsr    <= mag2;
      raw1   <= operand_1;
      sign_q <= neg1 ^ neg2;
      sign_r <= neg1;
      div0   <= (operand_2 == '0);
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      rem <= rem_nxt;
      qd  <= qd_nxt;
      if (last) begin
        if (div0) begin
          lo <= '1;
          hi <= raw1;
        end else begin
          lo <= q_fin;
          hi <= r_fin;
        end
      end
    end
  end
endmodule
